// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: FSM encoding, default byte width
// and an index-width helper that keeps single-requester builds at one bit.
package uart_tx_arbiter_pkg;

  localparam int DEFAULT_UART_DATA_SIZE = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } arb_state_t;

  function automatic int index_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: the first requesting index at or after the
// pointer, wrapping, plus a flag saying whether anyone is requesting at all.
module rr_priority_picker
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 2,
  parameter int IDX_W          = index_width(NUM_REQUESTERS)
) (
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic [IDX_W-1:0]          pointer,
  output logic [IDX_W-1:0]          winner,
  output logic                      any_valid
);

  int best_offset;
  int offset;

  // Rank every requester by its wrapped distance from the pointer; the closest wins.
  always_comb begin
    winner      = '0;
    any_valid   = |request;
    best_offset = NUM_REQUESTERS;
    offset      = 0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      if (request[k]) begin
        offset = (k + NUM_REQUESTERS - int'(pointer)) % NUM_REQUESTERS;
        if (offset < best_offset) begin
          best_offset = offset;
          winner      = IDX_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter in front of the shared UART transmitter,
// with a watchdog that frees the grant if the owner stalls mid-packet.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 2,
  parameter int UART_DATA_SIZE = DEFAULT_UART_DATA_SIZE,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TIMEOUT_SIZE   = 16
) (
  input  logic                                 i_clock,
  input  logic                                 i_reset,
  input  logic [NUM_REQUESTERS-1:0]            i_req_valid,
  input  logic [NUM_REQUESTERS-1:0]            i_req_last,
  input  logic [NUM_REQUESTERS*UART_DATA_SIZE-1:0] i_req_data,
  output logic [NUM_REQUESTERS-1:0]            o_req_ready,
  output logic [UART_DATA_SIZE-1:0]            o_tx_data,
  output logic                                 o_tx_valid,
  input  logic                                 i_tx_ready,
  output logic [NUM_REQUESTERS-1:0]            o_grant,
  output logic                                 o_busy,
  output logic                                 o_timeout
);

  localparam int IDX_W = index_width(NUM_REQUESTERS);
  localparam logic [TIMEOUT_SIZE-1:0] TIMEOUT_LIMIT = TIMEOUT_SIZE'(TIMEOUT_CYCLES - 1);

  arb_state_t                state;
  logic [IDX_W-1:0]          owner;
  logic [IDX_W-1:0]          rr_ptr;
  logic [UART_DATA_SIZE-1:0] tx_data;
  logic                      tx_last;
  logic                      tx_valid;
  logic [TIMEOUT_SIZE-1:0]   counter;
  logic [NUM_REQUESTERS-1:0] grant;
  logic                      busy;
  logic                      timeout;

  logic [IDX_W-1:0]          winner;
  logic                      any_valid;
  logic [NUM_REQUESTERS-1:0] req_ready;
  logic [UART_DATA_SIZE-1:0] req_bytes [NUM_REQUESTERS];

  for (genvar k = 0; k < NUM_REQUESTERS; k++) begin : g_unpack
    assign req_bytes[k] = i_req_data[k*UART_DATA_SIZE +: UART_DATA_SIZE];
  end

  function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx);
    if (int'(idx) >= NUM_REQUESTERS - 1) return '0;
    return idx + IDX_W'(1);
  endfunction

  function automatic logic [NUM_REQUESTERS-1:0] onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQUESTERS'(1) << idx;
  endfunction

  rr_priority_picker #(
    .NUM_REQUESTERS(NUM_REQUESTERS),
    .IDX_W         (IDX_W)
  ) u_picker (
    .request  (i_req_valid),
    .pointer  (rr_ptr),
    .winner   (winner),
    .any_valid(any_valid)
  );

  // Ready is withheld during reset so no requester believes a dropped byte was taken.
  always_comb begin
    req_ready = '0;
    if (!i_reset) begin
      case (state)
        IDLE:    if (any_valid) req_ready[winner] = 1'b1;
        HOLD:    req_ready[owner] = 1'b1;
        default: req_ready = '0;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      tx_data  <= '0;
      tx_last  <= 1'b0;
      tx_valid <= 1'b0;
      counter  <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            owner    <= winner;
            tx_data  <= req_bytes[winner];
            tx_last  <= i_req_last[winner];
            tx_valid <= 1'b1;
            grant    <= onehot(winner);
            busy     <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (i_tx_ready) begin
            tx_valid <= 1'b0;
            if (tx_last) begin
              state  <= IDLE;
              rr_ptr <= next_index(owner);
              grant  <= '0;
              busy   <= 1'b0;
            end else begin
              state   <= HOLD;
              counter <= '0;
            end
          end
        end
        HOLD: begin
          // A byte arriving on the limit cycle still wins over the watchdog.
          if (i_req_valid[owner]) begin
            tx_data  <= req_bytes[owner];
            tx_last  <= i_req_last[owner];
            tx_valid <= 1'b1;
            state    <= SEND;
          end else if (counter == TIMEOUT_LIMIT) begin
            state   <= IDLE;
            rr_ptr  <= next_index(owner);
            grant   <= '0;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end else begin
            counter <= counter + TIMEOUT_SIZE'(1);
          end
        end
        default: begin
          state    <= IDLE;
          tx_valid <= 1'b0;
          grant    <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready = req_ready;
  assign o_tx_data   = tx_data;
  assign o_tx_valid  = tx_valid;
  assign o_grant     = grant;
  assign o_busy      = busy;
  assign o_timeout   = timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with two requesters and an 8-cycle watchdog;
// expected values are worked out by hand from the intended cycle timing.
module tb_uart_tx_arbiter;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic [1:0]  i_req_valid;
  logic [1:0]  i_req_last;
  logic [15:0] i_req_data;
  logic [1:0]  o_req_ready;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic [1:0]  o_grant;
  logic        o_busy;
  logic        o_timeout;

  int check_count = 0;
  int pass_count  = 0;

  logic [8:0] queue0 [$];
  logic [8:0] queue1 [$];
  logic [7:0] expected_bytes [8] = '{8'h01, 8'h02, 8'h81, 8'h82, 8'h03, 8'h04, 8'h83, 8'h84};
  logic [1:0] expected_grant [8] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};

  uart_tx_arbiter #(
    .NUM_REQUESTERS(2),
    .UART_DATA_SIZE(8),
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_SIZE  (16)
  ) dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_req_valid(i_req_valid),
    .i_req_last (i_req_last),
    .i_req_data (i_req_data),
    .o_req_ready(o_req_ready),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_grant    (o_grant),
    .o_busy     (o_busy),
    .o_timeout  (o_timeout)
  );

  always #5 i_clock = ~i_clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] last,
                               input logic [7:0] data0, input logic [7:0] data1,
                               input logic tx_ready);
    i_req_valid = valid;
    i_req_last  = last;
    i_req_data  = {data1, data0};
    i_tx_ready  = tx_ready;
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic resetDut();
    i_reset = 1'b1;
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_time_limit: simulation did not finish, expected finish before 200000");
    $fatal(1, "[TB] time limit expired");
  end

  initial begin
    int received;
    int violations;
    int stall_errors;
    int early_pulses;
    int blocked_errors;
    int transfers;

    // Reset state
    resetDut();
    #1;
    checkOutput("reset_tx_valid", o_tx_valid, 1'b0);
    checkOutput("reset_tx_data", o_tx_data, 8'h00);
    checkOutput("reset_grant", o_grant, 2'b00);
    checkOutput("reset_busy", o_busy, 1'b0);
    checkOutput("reset_timeout", o_timeout, 1'b0);
    checkOutput("reset_req_ready", o_req_ready, 2'b00);

    // Three-byte packet from requester 0 with the UART always ready
    applyStimulus(2'b01, 2'b00, 8'h11, 8'h00, 1'b1);
    #1;
    checkOutput("t1_idle_ready", o_req_ready, 2'b01);
    tick();
    checkOutput("t1_b0_valid", o_tx_valid, 1'b1);
    checkOutput("t1_b0_data", o_tx_data, 8'h11);
    checkOutput("t1_b0_grant", o_grant, 2'b01);
    checkOutput("t1_send_ready", o_req_ready, 2'b00);
    applyStimulus(2'b01, 2'b00, 8'h22, 8'h00, 1'b1);
    tick();
    checkOutput("t1_hold_valid", o_tx_valid, 1'b0);
    checkOutput("t1_hold_grant", o_grant, 2'b01);
    checkOutput("t1_hold_ready", o_req_ready, 2'b01);
    tick();
    checkOutput("t1_b1_valid", o_tx_valid, 1'b1);
    checkOutput("t1_b1_data", o_tx_data, 8'h22);
    applyStimulus(2'b01, 2'b01, 8'h33, 8'h00, 1'b1);
    tick();
    checkOutput("t1_hold2_valid", o_tx_valid, 1'b0);
    tick();
    checkOutput("t1_b2_valid", o_tx_valid, 1'b1);
    checkOutput("t1_b2_data", o_tx_data, 8'h33);
    checkOutput("t1_b2_grant", o_grant, 2'b01);
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 1'b1);
    tick();
    checkOutput("t1_end_busy", o_busy, 1'b0);
    checkOutput("t1_end_grant", o_grant, 2'b00);
    checkOutput("t1_end_valid", o_tx_valid, 1'b0);

    // Both requesters streaming 2-byte packets: strict alternation, no interleave
    resetDut();
    queue0 = '{9'h001, 9'h102, 9'h003, 9'h104};
    queue1 = '{9'h081, 9'h182, 9'h083, 9'h184};
    received = 0;
    violations = 0;
    for (int cyc = 0; cyc < 200 && received < 8; cyc++) begin
      i_req_valid[0] = (queue0.size() > 0);
      i_req_valid[1] = (queue1.size() > 0);
      i_req_last[0]  = (queue0.size() > 0) ? queue0[0][8] : 1'b0;
      i_req_last[1]  = (queue1.size() > 0) ? queue1[0][8] : 1'b0;
      i_req_data[7:0]  = (queue0.size() > 0) ? queue0[0][7:0] : 8'h00;
      i_req_data[15:8] = (queue1.size() > 0) ? queue1[0][7:0] : 8'h00;
      i_tx_ready = 1'b1;
      #4;
      if (o_tx_valid && i_tx_ready) begin
        checkOutput($sformatf("t2_byte%0d", received), o_tx_data, expected_bytes[received]);
        checkOutput($sformatf("t2_grant%0d", received), o_grant, expected_grant[received]);
        received++;
      end
      if (o_busy && ((o_req_ready & ~o_grant) != 2'b00)) violations++;
      if (i_req_valid[0] && o_req_ready[0]) void'(queue0.pop_front());
      if (i_req_valid[1] && o_req_ready[1]) void'(queue1.pop_front());
      tick();
    end
    checkOutput("t2_bytes_seen", received, 8);
    checkOutput("t2_nonowner_ready", violations, 0);

    // UART stalls for 20 cycles in SEND
    resetDut();
    applyStimulus(2'b01, 2'b01, 8'h5C, 8'h00, 1'b0);
    tick();
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
    stall_errors = 0;
    for (int i = 0; i < 20; i++) begin
      if (!o_tx_valid || o_tx_data !== 8'h5C || !o_busy) stall_errors++;
      tick();
    end
    checkOutput("t4_stall_stable", stall_errors, 0);
    i_tx_ready = 1'b1;
    #1;
    checkOutput("t4_release_valid", o_tx_valid, 1'b1);
    tick();
    checkOutput("t4_done_valid", o_tx_valid, 1'b0);
    checkOutput("t4_done_busy", o_busy, 1'b0);

    // Owner goes silent in HOLD; watchdog hands over to requester 1
    resetDut();
    applyStimulus(2'b11, 2'b10, 8'h21, 8'h91, 1'b1);
    tick();
    checkOutput("t5_first_grant", o_grant, 2'b01);
    checkOutput("t5_first_data", o_tx_data, 8'h21);
    applyStimulus(2'b10, 2'b10, 8'h00, 8'h91, 1'b1);
    tick();
    early_pulses = 0;
    blocked_errors = 0;
    for (int i = 1; i <= 8; i++) begin
      if (o_req_ready[1]) blocked_errors++;
      tick();
      if (i < 8 && o_timeout) early_pulses++;
    end
    checkOutput("t5_early_timeout", early_pulses, 0);
    checkOutput("t5_nonowner_blocked", blocked_errors, 0);
    checkOutput("t5_timeout_pulse", o_timeout, 1'b1);
    checkOutput("t5_timeout_busy", o_busy, 1'b0);
    checkOutput("t5_timeout_grant", o_grant, 2'b00);
    applyStimulus(2'b11, 2'b10, 8'h22, 8'h91, 1'b1);
    #1;
    checkOutput("t5_rr_advanced_ready", o_req_ready, 2'b10);
    tick();
    checkOutput("t5_pulse_ends", o_timeout, 1'b0);
    checkOutput("t5_new_grant", o_grant, 2'b10);
    checkOutput("t5_new_data", o_tx_data, 8'h91);

    // Reset during SEND drops the pending byte
    resetDut();
    applyStimulus(2'b01, 2'b01, 8'h5A, 8'h00, 1'b0);
    tick();
    checkOutput("t6_send_data", o_tx_data, 8'h5A);
    i_reset = 1'b1;
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
    tick();
    checkOutput("t6_reset_valid", o_tx_valid, 1'b0);
    checkOutput("t6_reset_grant", o_grant, 2'b00);
    checkOutput("t6_reset_busy", o_busy, 1'b0);
    i_reset = 1'b0;
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 1'b1);
    transfers = 0;
    for (int i = 0; i < 6; i++) begin
      if (o_tx_valid && i_tx_ready) transfers++;
      tick();
    end
    checkOutput("t6_no_transfer", transfers, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter between several byte-stream requesters (status logger, command responder, debug dump). Each requester offers a packet of bytes under valid/ready with a last flag. The arbiter grants one requester at a time, round-robin, and keeps the grant locked until the requester's last byte is accepted. A watchdog releases a grant that stalls mid-packet. It sits between the requesters and the UART TX input (`tx_data` / `tx_valid` / `tx_ready`).

## Interface
- `NUM_REQUESTERS`, default 2: number of requester ports, minimum 1.
- `UART_DATA_SIZE`, default 8: byte width.
- `TIMEOUT_CYCLES`, default 1000: idle cycles allowed inside a locked packet before the grant is released.
- `TIMEOUT_SIZE`, default 16: counter width; `TIMEOUT_CYCLES` < 2^`TIMEOUT_SIZE`.

Ports:
- `i_clock`  in  1  single clock, rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_req_valid`  in  NUM_REQUESTERS  byte offered; requester k uses bit k.
- `i_req_last`  in  NUM_REQUESTERS  offered byte ends the packet.
- `i_req_data`  in  NUM_REQUESTERS*UART_DATA_SIZE  requester k uses `[k*UART_DATA_SIZE +: UART_DATA_SIZE]`.
- `o_req_ready`  out  NUM_REQUESTERS  byte accepted this cycle when ANDed with valid.
- `o_tx_data`  out  UART_DATA_SIZE  byte to UART.
- `o_tx_valid`  out  1  `o_tx_data` valid.
- `i_tx_ready`  in  1  UART takes the byte when high together with `o_tx_valid`.
- `o_grant`  out  NUM_REQUESTERS  one-hot current owner; all zero when idle.
- `o_busy`  out  1  high whenever state is not IDLE.
- `o_timeout`  out  1  one-cycle pulse on watchdog release.

## Operation
- Registered state: `state`, `owner`, `rr_ptr`, `tx_data`, `tx_last`, `tx_valid`, `counter`.
- IDLE:
  - Winner = first k with `i_req_valid[k]`, scanning from `rr_ptr` upward and wrapping at NUM_REQUESTERS-1 to 0.
  - `o_req_ready[winner]`=1. Capture the winner's data and last, set `owner`=winner, go to SEND.
  - No valid: remain in IDLE.
- SEND:
  - `o_tx_valid`=1; data held stable; all `o_req_ready`=0.
  - On `i_tx_ready`: if `tx_last`, go to IDLE and set `rr_ptr`=(owner+1) mod N. Otherwise go to HOLD and set `counter`=0.
- HOLD:
  - `o_tx_valid`=0; `o_req_ready[owner]`=1, all others 0.
  - Owner valid: capture the byte, go to SEND.
  - Owner not valid: `counter`++. When `counter`==TIMEOUT_CYCLES-1, go to IDLE, advance `rr_ptr` past owner, and pulse `o_timeout`.
- Non-owner valid is ignored while `o_busy`. Requesters hold valid and data stable until ready; behaviour otherwise is undefined.
- A byte with last set in IDLE is a single-byte packet and goes straight back to IDLE after its SEND.
- `o_grant` = onehot(owner) in SEND and HOLD, 0 in IDLE.
- N=1: `rr_ptr` is constant 0; the lock and timeout still apply.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `owner` 0, `counter` 0, `o_tx_data` 0, `o_tx_valid` 0, `o_grant` 0, `o_busy` 0, `o_timeout` 0, `o_req_ready` 0.
- Reset mid-SEND or mid-HOLD drops the pending byte and the lock. Outputs take reset values on the next edge.
- `o_req_ready` is combinational from registered state and `i_req_valid`. This valid→ready path is intentional.
- Latency: accept at cycle t → `o_tx_valid` at t+1.
- Back-to-back bytes within a packet: UART accept at t, HOLD at t+1, owner byte captured at t+1, `o_tx_valid` at t+2. Minimum 2 cycles per byte.
- Packet end: last byte accepted at t, IDLE at t+1. The next winner is accepted at t+1 and its `o_tx_valid` rises at t+2.
- Watchdog: HOLD entered at t with the owner silent → IDLE at t+TIMEOUT_CYCLES, `o_timeout` high in that cycle only.
- Owner valid arriving in the same cycle `counter` reaches the limit: the byte is captured and the timeout is not taken.
- `i_tx_ready` high outside SEND is ignored.

## Structure
- Shared package holds:
  - state encoding localparams: IDLE=0, SEND=1, HOLD=2, 2-bit state;
  - `UART_DATA_SIZE` default, shared with the logger and the UART TX.
- One sub-module `rr_priority_picker`:
  - combinational; inputs request vector and pointer;
  - outputs winner index and an any-valid flag.

## Test plan
- Reset, then requester 0 sends 3 bytes 0x11, 0x22, 0x33 (last on 0x33), `i_tx_ready` tied 1 → UART sees 0x11, 0x22, 0x33, `o_tx_valid` high every other cycle, `o_grant`=01 throughout, IDLE after.
- Both requesters valid continuously, each sending 2-byte packets, reset `rr_ptr`=0 → packets alternate 0,1,0,1 and bytes of different packets never interleave.
- Requester 1 mid-packet while requester 0 asserts valid → requester 0 `o_req_ready` stays 0 until requester 1's last byte is accepted.
- `i_tx_ready` held low for 20 cycles in SEND → `o_tx_data` stable and valid high for all 20 cycles; transfer completes on the first ready cycle.
- Owner silent in HOLD with TIMEOUT_CYCLES=8 → `o_timeout` pulses exactly 8 cycles after HOLD entry, the grant passes to the other valid requester, and `rr_ptr` advances.
- `i_reset` asserted during SEND of 0x5A → next cycle `o_tx_valid`=0, `o_grant`=0, `o_busy`=0, and 0x5A is never transferred.
